// File: rtl/hub75_pkg.sv
// HUB75 receiver shared package: panel geometry defaults, pin/status widths
// and the buffered column-pair entry type.
package hub75_pkg;

    // Panel geometry and pin widths shared with the panel driver side
    localparam int HUB75_WIDTH  = 64;
    localparam int HUB75_ROWS   = 32;
    localparam int HUB75_ADDR_W = 5;
    localparam int HUB75_RGB_W  = 3;

    // Receiver coordinate and status widths
    localparam int HUB75_COL_W  = 6;
    localparam int HUB75_LEN_W  = 7;
    localparam int HUB75_ON_W   = 16;

    typedef struct packed {
        logic [HUB75_COL_W-1:0]  x;
        logic [HUB75_ADDR_W-1:0] row;
        logic [HUB75_RGB_W-1:0]  rgb0;
        logic [HUB75_RGB_W-1:0]  rgb1;
    } hub75_px_t;

endpackage

// File: rtl/hub75_receiver_if.sv
// Pixel stream valid/ready bundle.
// master: drives valid/x/y/rgb, samples ready. slave: the reverse.
interface hub75_receiver_if;
    import hub75_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [HUB75_COL_W-1:0] x;
    logic [HUB75_COL_W-1:0] y;
    logic [HUB75_RGB_W-1:0] rgb;

    modport master (output valid, output x, output y, output rgb,
                    input  ready);
    modport slave  (input  valid, input  x, input  y, input  rgb,
                    output ready);

endinterface

// File: rtl/hub75_rx_fifo.sv
// Single-clock FIFO of column-pair entries with full/empty flags.
// Ports: clk, rst (sync, high), i_push/i_data, i_pop, o_data (head), o_full, o_empty.
module hub75_rx_fifo
    import hub75_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  hub75_px_t i_data,
    input  logic      i_pop,
    output hub75_px_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    hub75_px_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd];

    // Pointer wrap that also works for non-power-of-two depths
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/hub75_receiver.sv
// HUB75 panel-pin receiver: synchronizes the pins, buffers shifted column pairs
// and streams them as upper/lower pixel beats, with per-row latch statistics.
// Ports: clk, rst (sync, high); i_cl/i_la/i_bl/i_a/i_{r,g,b}{0,1} panel pins;
// px pixel stream (master); o_row_done, o_row_len, o_row_on, o_frame_start,
// o_overflow, o_length_err status.
module hub75_receiver
    import hub75_pkg::*;
#(
    parameter int WIDTH      = HUB75_WIDTH,
    parameter int ROWS       = HUB75_ROWS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cl,
    input  logic                    i_la,
    input  logic                    i_bl,
    input  logic [HUB75_ADDR_W-1:0] i_a,
    input  logic                    i_r0,
    input  logic                    i_g0,
    input  logic                    i_b0,
    input  logic                    i_r1,
    input  logic                    i_g1,
    input  logic                    i_b1,
    hub75_receiver_if.master        px,
    output logic                    o_row_done,
    output logic [HUB75_LEN_W-1:0]  o_row_len,
    output logic [HUB75_ON_W-1:0]   o_row_on,
    output logic                    o_frame_start,
    output logic                    o_overflow,
    output logic                    o_length_err
);

    localparam int PINS = 14;

    logic [PINS-1:0]         w_pins;
    logic [PINS-1:0]         r_s1;
    logic [PINS-1:0]         r_s2;
    logic                    r_cl_d;
    logic                    r_la_d;
    logic [1:0]              r_guard;
    logic [HUB75_COL_W-1:0]  r_col;
    logic [HUB75_LEN_W-1:0]  r_cl_cnt;
    logic [HUB75_ON_W-1:0]   r_on_cnt;
    logic                    r_lower;

    logic                    w_cl;
    logic                    w_la;
    logic                    w_bl;
    logic [HUB75_ADDR_W-1:0] w_a;
    logic                    w_cl_rise;
    logic                    w_la_rise;
    logic [HUB75_LEN_W-1:0]  w_len_now;
    hub75_px_t               w_entry;
    hub75_px_t               w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;

    assign w_pins = {i_cl, i_la, i_bl, i_a,
                     i_r0, i_g0, i_b0, i_r1, i_g1, i_b1};

    // Synchronizers and edge history track the pins even during reset, so a
    // pin already high at release is never mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        r_s1   <= w_pins;
        r_s2   <= r_s1;
        r_cl_d <= w_cl;
        r_la_d <= w_la;
    end

    assign w_cl = r_s2[13];
    assign w_la = r_s2[12];
    assign w_bl = r_s2[11];
    assign w_a  = r_s2[10:6];

    assign w_cl_rise = w_cl && !r_cl_d && (r_guard == 2'd0);
    assign w_la_rise = w_la && !r_la_d && (r_guard == 2'd0);

    assign w_entry = '{x: r_col, row: w_a, rgb0: r_s2[5:3], rgb1: r_s2[2:0]};

    // Edge landing on the latch cycle still belongs to the row being closed
    assign w_len_now = (w_cl_rise && r_cl_cnt != '1) ? r_cl_cnt + 1'b1
                                                     : r_cl_cnt;

    hub75_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cl_rise),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Two beats per entry; the head is only released after the lower beat
    assign px.valid = !w_empty;
    assign px.x     = w_head.x;
    assign px.y     = r_lower ? {1'b0, w_head.row} + HUB75_COL_W'(ROWS)
                              : {1'b0, w_head.row};
    assign px.rgb   = r_lower ? w_head.rgb1 : w_head.rgb0;
    assign w_pop    = px.valid && px.ready && r_lower;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_guard       <= 2'd3;
            r_col         <= '0;
            r_cl_cnt      <= '0;
            r_on_cnt      <= '0;
            r_lower       <= 1'b0;
            o_row_done    <= 1'b0;
            o_row_len     <= '0;
            o_row_on      <= '0;
            o_frame_start <= 1'b0;
            o_overflow    <= 1'b0;
            o_length_err  <= 1'b0;
        end else begin
            if (r_guard != 2'd0) r_guard <= r_guard - 2'd1;
            if (px.valid && px.ready) r_lower <= !r_lower;
            o_row_done    <= w_la_rise;
            o_frame_start <= w_la_rise && (w_a == '0);
            if (w_cl_rise && w_full) o_overflow <= 1'b1;
            if (w_la_rise) begin
                r_col     <= '0;
                r_cl_cnt  <= '0;
                r_on_cnt  <= '0;
                o_row_len <= w_len_now;
                o_row_on  <= r_on_cnt;
                if (w_len_now != HUB75_LEN_W'(WIDTH)) o_length_err <= 1'b1;
            end else begin
                if (w_cl_rise) begin
                    r_col    <= r_col + 1'b1;
                    r_cl_cnt <= w_len_now;
                end
                if (!w_bl && r_on_cnt != '1) r_on_cnt <= r_on_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hub75_receiver.sv
// Self-checking bench for hub75_receiver against a queue-based pixel model.
// Ports: none (top-level bench).
module tb_hub75_receiver;
    import hub75_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cl = 1'b0, la = 1'b0, bl = 1'b1;
    logic [4:0] a = '0;
    logic [2:0] c0 = '0, c1 = '0;
    logic       row_done, frame_start, overflow, length_err;
    logic [6:0] row_len;
    logic [15:0] row_on;

    hub75_receiver_if px_if();

    hub75_receiver dut (
        .clk           (clk),
        .rst           (rst),
        .i_cl          (cl),
        .i_la          (la),
        .i_bl          (bl),
        .i_a           (a),
        .i_r0          (c0[2]),
        .i_g0          (c0[1]),
        .i_b0          (c0[0]),
        .i_r1          (c1[2]),
        .i_g1          (c1[1]),
        .i_b1          (c1[0]),
        .px            (px_if),
        .o_row_done    (row_done),
        .o_row_len     (row_len),
        .o_row_on      (row_on),
        .o_frame_start (frame_start),
        .o_overflow    (overflow),
        .o_length_err  (length_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_beats = 0, n_rd = 0, n_fs = 0;
    // Model state
    logic [14:0] q[$];
    int  m_col = 0, m_len = 0, m_last = 0, m_rd = 0, m_fs = 0;
    bit  m_err = 0, m_ovf = 0;
    bit  rnd_rdy = 0, rdy_fix = 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        px_if.ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end

    // Output monitor: beat order, hold-while-stalled, status pulse counts
    bit          stall = 0;
    logic [14:0] held;
    logic [14:0] cur;
    always @(negedge clk) begin
        cur = {px_if.x, px_if.y, px_if.rgb};
        if (rst) begin
            stall = 0;
        end else begin
            if (row_done) n_rd++;
            if (frame_start) n_fs++;
            if (stall) check("hold", {px_if.valid, cur}, {1'b1, held});
            if (px_if.valid && px_if.ready) begin
                n_beats++;
                check("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) check("beat", cur, q.pop_front());
            end
            stall = px_if.valid && !px_if.ready;
            held  = cur;
        end
    end

    function automatic void model_push(input logic [4:0] aa,
                                       input logic [2:0] u, input logic [2:0] l,
                                       input bit keep);
        if (keep) begin
            q.push_back({6'(m_col), {1'b0, aa}, u});
            q.push_back({6'(m_col), 6'(aa + 32), l});
        end
        m_col = (m_col + 1) % 64;
        m_len = (m_len < 127) ? m_len + 1 : 127;
    endfunction

    function automatic void model_latch(input logic [4:0] aa);
        m_last = m_len;
        if (m_len != 64) m_err = 1;
        m_rd++;
        if (aa == 0) m_fs++;
        m_col = 0;
        m_len = 0;
    endfunction

    task automatic cl_edge(input logic [4:0] aa, input logic [2:0] u,
                           input logic [2:0] l, input bit keep);
        a = aa; c0 = u; c1 = l;
        repeat (2) tick();
        cl = 1'b1;
        model_push(aa, u, l, keep);
        repeat (3) tick();
        cl = 1'b0;
        repeat (2) tick();
    endtask

    task automatic check_latch(input string tag, input int exp_on);
        @(negedge clk);
        check({tag, "_len"}, row_len, m_last);
        check({tag, "_err"}, length_err, m_err);
        check({tag, "_done"}, n_rd, m_rd);
        check({tag, "_frame"}, n_fs, m_fs);
        check({tag, "_ovf"}, overflow, m_ovf);
        if (exp_on >= 0) check({tag, "_on"}, row_on, exp_on);
    endtask

    task automatic la_pulse(input logic [4:0] aa, input string tag,
                            input int exp_on);
        a = aa;
        repeat (2) tick();
        la = 1'b1;
        model_latch(aa);
        repeat (3) tick();
        la = 1'b0;
        repeat (3) tick();
        check_latch(tag, exp_on);
    endtask

    task automatic cl_la(input logic [4:0] aa, input logic [2:0] u,
                         input logic [2:0] l, input string tag);
        a = aa; c0 = u; c1 = l;
        repeat (2) tick();
        cl = 1'b1;
        la = 1'b1;
        model_push(aa, u, l, 1);
        model_latch(aa);
        repeat (3) tick();
        cl = 1'b0;
        la = 1'b0;
        repeat (3) tick();
        check_latch(tag, 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4000 && q.size() != 0; i++) tick();
        repeat (2) tick();
        @(negedge clk);
        check({tag, "_left"}, q.size(), 0);
        check({tag, "_valid"}, px_if.valid, 0);
    endtask

    int b0;
    logic [4:0] ra;

    initial begin
        px_if.ready = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", px_if.valid, 0);
        check("rst_done", row_done, 0);
        check("rst_frame", frame_start, 0);
        check("rst_len", row_len, 0);
        check("rst_on", row_on, 0);
        check("rst_ovf", overflow, 0);
        check("rst_err", length_err, 0);
        repeat (4) tick();

        // Full row, red on even columns upper, green everywhere lower
        b0 = n_beats;
        for (int x = 0; x < 64; x++)
            cl_edge(5'd5, (x % 2 == 0) ? 3'b100 : 3'b000, 3'b010, 1);
        la_pulse(5'd5, "row64", 0);
        drain("row64");
        check("row64_beats", n_beats - b0, 128);

        // Random full rows with a randomly stalling consumer
        rnd_rdy = 1;
        for (int r = 0; r < 3; r++) begin
            ra = 5'($urandom_range(0, 31));
            if (r == 1) ra = 5'd0;
            for (int x = 0; x < 64; x++)
                cl_edge(ra, 3'($urandom), 3'($urandom), 1);
            la_pulse(ra, "rndrow", 0);
        end
        drain("rnd");

        // Short row flags a length error; next row restarts at column 0
        for (int x = 0; x < 63; x++)
            cl_edge(5'd9, 3'($urandom), 3'($urandom), 1);
        la_pulse(5'd9, "short63", 0);
        for (int x = 0; x < 5; x++)
            cl_edge(5'd10, 3'($urandom), 3'($urandom), 1);
        la_pulse(5'd10, "after63", 0);
        drain("short");

        // Shift edge coincident with latch
        for (int x = 0; x < 9; x++)
            cl_edge(5'd12, 3'($urandom), 3'($urandom), 1);
        cl_la(5'd12, 3'b111, 3'b101, "same");
        for (int x = 0; x < 3; x++)
            cl_edge(5'd13, 3'($urandom), 3'($urandom), 1);
        la_pulse(5'd13, "post_same", 0);
        drain("same");

        // Display-on time accumulation and frame start
        bl = 1'b0;
        repeat (200) tick();
        bl = 1'b1;
        la_pulse(5'd0, "frame", -1);
        check("row_on_200", (row_on >= 197) && (row_on <= 203), 1);

        // Overflow with a stalled consumer
        rnd_rdy = 0;
        rdy_fix = 0;
        repeat (3) tick();
        for (int x = 0; x < 6; x++)
            cl_edge(5'd20, 3'($urandom), 3'($urandom), x < 4);
        m_ovf = 1;
        @(negedge clk);
        check("ovf_set", overflow, 1);
        check("ovf_valid", px_if.valid, 1);
        check("ovf_q", q.size(), 8);
        rdy_fix = 1;
        drain("ovf");

        // Reset mid-row with a pending beat and CL held high
        rdy_fix = 0;
        cl_edge(5'd3, 3'b001, 3'b110, 1);
        cl_edge(5'd3, 3'b011, 3'b100, 1);
        a = 5'd3;
        repeat (2) tick();
        cl = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid_valid", px_if.valid, 0);
        check("mid_done", row_done, 0);
        check("mid_frame", frame_start, 0);
        check("mid_len", row_len, 0);
        check("mid_on", row_on, 0);
        check("mid_ovf", overflow, 0);
        check("mid_err", length_err, 0);
        q.delete();
        m_col = 0; m_len = 0; m_ovf = 0; m_err = 0;
        rdy_fix = 1;
        repeat (3) tick();
        rst = 1'b0;
        b0 = n_beats;
        repeat (10) tick();
        @(negedge clk);
        check("no_spurious_beats", n_beats - b0, 0);
        check("no_spurious_valid", px_if.valid, 0);
        cl = 1'b0;
        repeat (2) tick();
        for (int x = 0; x < 4; x++)
            cl_edge(5'd7, 3'($urandom), 3'($urandom), 1);
        la_pulse(5'd7, "post_rst", 0);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
